// File: rtl/freq_meter.sv
// freq_meter: measures the period and high time of a slow asynchronous
// square wave in clk cycles. It publishes one result per input period with
// a one-cycle valid strobe, and sets a sticky timeout flag when the input
// stops toggling.
module freq_meter #(
    parameter int CNTR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  sig_in,
    output logic [CNTR_WIDTH-1:0] period,
    output logic [CNTR_WIDTH-1:0] high_time,
    output logic                  valid,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);
    localparam logic [CNTR_WIDTH-1:0] CNT_MAX = '1;

    state_t state_q, state_d;

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [CNTR_WIDTH-1:0] period_q, period_d;
    logic [CNTR_WIDTH-1:0] high_time_q, high_time_d;
    logic                  valid_q, valid_d;
    logic                  timeout_q, timeout_d;

    logic rise;
    logic cnt_max;

    // s1/s2 resolve metastability; s3 is the previous s2, used for edge detection.
    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    assign rise    = s2_q & ~s3_q;
    assign cnt_max = (cnt_q == CNT_MAX);

    // Synchronizer flops; these run whether or not enable is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Dropping enable has priority over edges and timeout.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (rise) state_d = MEAS;
                MEAS:    if (!rise && cnt_max) state_d = ARM;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counters and results. An edge coinciding with a saturated counter is
    // taken as a measurement, so the longest period is still reported.
    always_comb begin
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        if (!enable) begin
            cnt_d  = '0;
            hcnt_d = '0;
        end else begin
            case (state_q)
                ARM: begin
                    if (rise) begin
                        cnt_d  = CNT_ONE;
                        hcnt_d = CNT_ONE;
                    end else begin
                        cnt_d  = '0;
                        hcnt_d = '0;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hcnt_q;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
                        cnt_d       = CNT_ONE;
                        hcnt_d      = CNT_ONE;
                    end else if (cnt_max) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        // hcnt never exceeds cnt, so it cannot wrap either.
                        if (s2_q) hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d  = '0;
                    hcnt_d = '0;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter at CNTR_WIDTH=4, so saturation and timeout
// are reachable in a few cycles.
module tb_freq_meter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;

    int n_vec = 0;
    int n_err = 0;

    // Monitor state, sampled 1 time unit after each rising edge.
    int           cyc = 0;
    int           vcnt = 0;
    int           lvcyc = 0;
    logic [W-1:0] lp = '0;
    logic [W-1:0] lh = '0;
    int           rise_cyc = 0;

    freq_meter #(.CNTR_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (valid) begin
            vcnt++;
            lvcyc = cyc;
            lp    = period;
            lh    = high_time;
        end
    end

    // Drive cnt periods of n cycles with h high, changing at falling edges.
    task automatic wave(input int n, input int h, input int cnt);
        for (int p = 0; p < cnt; p++) begin
            rise_cyc = cyc;
            sig_in   = 1'b1;
            repeat (h) @(negedge clk);
            sig_in = 1'b0;
            repeat (n - h) @(negedge clk);
        end
    endtask

    // Toggle enable to force a fresh ARM.
    task automatic restart();
        @(negedge clk);
        sig_in = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; sig_in = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (period !== 4'd0) begin n_err++; $display("FAIL reset_period got %0d want 0", period); end
        n_vec++; if (high_time !== 4'd0) begin n_err++; $display("FAIL reset_high got %0d want 0", high_time); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", timeout); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div10();
        int v0;
        restart();
        v0 = vcnt;
        wave(10, 5, 4);
        n_vec++; if (vcnt - v0 !== 3) begin n_err++; $display("FAIL div10_count got %0d want 3", vcnt - v0); end
        n_vec++; if (lp !== 4'd10) begin n_err++; $display("FAIL div10_period got %0d want 10", lp); end
        n_vec++; if (lh !== 4'd5) begin n_err++; $display("FAIL div10_high got %0d want 5", lh); end
        n_vec++; if (lvcyc - rise_cyc !== 3) begin n_err++; $display("FAIL div10_latency got %0d want 3", lvcyc - rise_cyc); end
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL div10_timeout got %b want 0", timeout); end
    endtask

    task automatic test_fast();
        int v0;
        restart();
        v0 = vcnt;
        wave(2, 1, 4);
        // The fourth edge's valid is still in flight here.
        n_vec++; if (vcnt - v0 !== 2) begin n_err++; $display("FAIL fast_count got %0d want 2", vcnt - v0); end
        n_vec++; if (lp !== 4'd2) begin n_err++; $display("FAIL fast_period got %0d want 2", lp); end
        n_vec++; if (lh !== 4'd1) begin n_err++; $display("FAIL fast_high got %0d want 1", lh); end
        wave(4, 1, 3);
        n_vec++; if (vcnt - v0 !== 6) begin n_err++; $display("FAIL p4_count got %0d want 6", vcnt - v0); end
        n_vec++; if (lp !== 4'd4) begin n_err++; $display("FAIL p4_period got %0d want 4", lp); end
        n_vec++; if (lh !== 4'd1) begin n_err++; $display("FAIL p4_high got %0d want 1", lh); end
    endtask

    task automatic test_timeout();
        int v0;
        restart();
        v0 = vcnt;
        wave(6, 3, 1);
        // Edge driven at cycle k enters MEAS at k+3; cnt hits 15 at k+17.
        repeat (11) @(negedge clk);
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_early got %b want 0", timeout); end
        @(negedge clk);
        n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_set got %b want 1", timeout); end
        n_vec++; if (vcnt - v0 !== 0) begin n_err++; $display("FAIL to_novalid got %0d want 0", vcnt - v0); end
        wave(6, 3, 1);
        n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_armhold got %b want 1", timeout); end
        n_vec++; if (vcnt - v0 !== 0) begin n_err++; $display("FAIL to_armonly got %0d want 0", vcnt - v0); end
        wave(6, 3, 2);
        n_vec++; if (vcnt - v0 !== 2) begin n_err++; $display("FAIL to_resume_count got %0d want 2", vcnt - v0); end
        n_vec++; if (lp !== 4'd6) begin n_err++; $display("FAIL to_resume_period got %0d want 6", lp); end
        n_vec++; if (lh !== 4'd3) begin n_err++; $display("FAIL to_resume_high got %0d want 3", lh); end
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_clear got %b want 0", timeout); end
    endtask

    task automatic test_saturate();
        int v0;
        restart();
        v0 = vcnt;
        wave(15, 7, 3);
        n_vec++; if (vcnt - v0 !== 2) begin n_err++; $display("FAIL sat_count got %0d want 2", vcnt - v0); end
        n_vec++; if (lp !== 4'd15) begin n_err++; $display("FAIL sat_period got %0d want 15", lp); end
        n_vec++; if (lh !== 4'd7) begin n_err++; $display("FAIL sat_high got %0d want 7", lh); end
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL sat_timeout got %b want 0", timeout); end
    endtask

    task automatic test_enable();
        int v0;
        int v1;
        restart();
        v0 = vcnt;
        wave(10, 5, 2);
        n_vec++; if (vcnt - v0 !== 1) begin n_err++; $display("FAIL en_pre_count got %0d want 1", vcnt - v0); end
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        sig_in = 1'b0;
        repeat (2) @(negedge clk);
        v1 = vcnt;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (vcnt !== v1) begin n_err++; $display("FAIL en_off_valid got %0d want %0d", vcnt, v1); end
        n_vec++; if (period !== 4'd10) begin n_err++; $display("FAIL en_hold_period got %0d want 10", period); end
        n_vec++; if (high_time !== 4'd5) begin n_err++; $display("FAIL en_hold_high got %0d want 5", high_time); end
        wave(7, 3, 1);
        n_vec++; if (vcnt !== v1) begin n_err++; $display("FAIL en_rearm got %0d want %0d", vcnt, v1); end
        wave(7, 3, 2);
        n_vec++; if (vcnt - v1 !== 2) begin n_err++; $display("FAIL en_post_count got %0d want 2", vcnt - v1); end
        n_vec++; if (lp !== 4'd7) begin n_err++; $display("FAIL en_post_period got %0d want 7", lp); end
        n_vec++; if (lh !== 4'd3) begin n_err++; $display("FAIL en_post_high got %0d want 3", lh); end
    endtask

    task automatic test_rst_mid();
        int v0;
        restart();
        wave(8, 4, 2);
        sig_in = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        sig_in = 1'b0;
        #1;
        n_vec++; if (period !== 4'd0) begin n_err++; $display("FAIL rst_period got %0d want 0", period); end
        n_vec++; if (high_time !== 4'd0) begin n_err++; $display("FAIL rst_high got %0d want 0", high_time); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", valid); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        v0 = vcnt;
        wave(8, 4, 1);
        n_vec++; if (vcnt !== v0) begin n_err++; $display("FAIL rst_stale got %0d want %0d", vcnt, v0); end
        n_vec++; if (period !== 4'd0) begin n_err++; $display("FAIL rst_armonly got %0d want 0", period); end
        wave(8, 4, 2);
        n_vec++; if (vcnt - v0 !== 2) begin n_err++; $display("FAIL rst_resume_count got %0d want 2", vcnt - v0); end
        n_vec++; if (lp !== 4'd8) begin n_err++; $display("FAIL rst_resume_period got %0d want 8", lp); end
        n_vec++; if (lh !== 4'd4) begin n_err++; $display("FAIL rst_resume_high got %0d want 4", lh); end
    endtask

    task automatic test_change();
        restart();
        wave(10, 5, 3);
        n_vec++; if (lp !== 4'd10) begin n_err++; $display("FAIL chg_before got %0d want 10", lp); end
        // The first 7-cycle edge closes the last 10-cycle period.
        wave(7, 3, 1);
        n_vec++; if (lp !== 4'd10) begin n_err++; $display("FAIL chg_boundary got %0d want 10", lp); end
        wave(7, 3, 1);
        n_vec++; if (lp !== 4'd7) begin n_err++; $display("FAIL chg_after got %0d want 7", lp); end
        n_vec++; if (lh !== 4'd3) begin n_err++; $display("FAIL chg_high got %0d want 3", lh); end
    endtask

    initial begin
        test_reset();
        test_div10();
        test_fast();
        test_timeout();
        test_saturate();
        test_enable();
        test_rst_mid();
        test_change();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
